// File: rtl/graphics_pkg.sv
// Shared graphics constants and types for the pixel-write engines.
// Display geometry, address type and the line engine state encoding.
package graphics_pkg;

    localparam int DISPLAY_WIDTH  = 640;
    localparam int DISPLAY_HEIGHT = 400;
    localparam int COORD_WIDTH    = 10;
    localparam int ADDRESS_WIDTH  = 18;
    localparam int ERROR_WIDTH    = 12;
    localparam int COLOR_WIDTH    = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        DONE
    } vector_state_t;

    typedef logic [ADDRESS_WIDTH-1:0] pixel_address_t;
    typedef logic [COORD_WIDTH-1:0]   coord_t;

    function automatic coord_t clamp_coord(input coord_t c, input coord_t lim);
        return (c > lim) ? lim : c;
    endfunction

endpackage

// File: rtl/vector_engine.sv
// Bresenham line rasteriser feeding the vector slot of the pixel-write mux.
// One pixel per granted cycle; reports the end point when the line is done.
module vector_engine
    import graphics_pkg::*;
(
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic [COORD_WIDTH-1:0]   cursor_start_x_position_in,
    input  logic [COORD_WIDTH-1:0]   cursor_start_y_position_in,
    input  logic [COORD_WIDTH-1:0]   line_end_x_in,
    input  logic [COORD_WIDTH-1:0]   line_end_y_in,
    input  logic [COLOR_WIDTH-1:0]   color_index_in,
    input  logic                     draw_start_in,
    input  logic                     pixel_write_grant_in,
    output logic                     busy_out,
    output logic                     pixel_write_enable_out,
    output logic [ADDRESS_WIDTH-1:0] pixel_write_address_out,
    output logic [COLOR_WIDTH-1:0]   pixel_write_data_out,
    output logic                     cursor_end_position_valid_out,
    output logic [COORD_WIDTH-1:0]   cursor_end_x_position_out,
    output logic [COORD_WIDTH-1:0]   cursor_end_y_position_out
);

    localparam coord_t         MAX_X      = coord_t'(DISPLAY_WIDTH - 1);
    localparam coord_t         MAX_Y      = coord_t'(DISPLAY_HEIGHT - 1);
    localparam pixel_address_t ROW_STRIDE = pixel_address_t'(DISPLAY_WIDTH);

    vector_state_t state_q, state_d;

    coord_t                        x_q, y_q, x1_q, y1_q;
    logic [COLOR_WIDTH-1:0]        color_q;
    logic signed [ERROR_WIDTH-1:0] dx_q, dy_q, err_q;
    logic                          sx_neg_q, sy_neg_q;
    pixel_address_t                addr_q;

    logic                   busy_q, enable_q, done_q;
    logic                   busy_d, enable_d, done_d;
    logic [COLOR_WIDTH-1:0] data_q;
    coord_t                 end_x_q, end_y_q;

    coord_t                        dx_abs, dy_abs;
    logic signed [ERROR_WIDTH-1:0] dx_init, dy_init;
    pixel_address_t                row_base;

    logic signed [ERROR_WIDTH:0]   e2, dx_wide, dy_wide;
    logic signed [ERROR_WIDTH-1:0] err_step;
    logic                          step_x, step_y, at_end, advance;
    pixel_address_t                addr_dx, addr_dy;

    // Line geometry from the captured end points; only consumed in SETUP.
    always_comb begin
        dx_abs  = (x1_q >= x_q) ? x1_q - x_q : x_q - x1_q;
        dy_abs  = (y1_q >= y_q) ? y1_q - y_q : y_q - y1_q;
        dx_init = $signed({{(ERROR_WIDTH-COORD_WIDTH){1'b0}}, dx_abs});
        dy_init = -$signed({{(ERROR_WIDTH-COORD_WIDTH){1'b0}}, dy_abs});
        row_base = (pixel_address_t'(y_q) << 9)
                 + (pixel_address_t'(y_q) << 7)
                 + pixel_address_t'(x_q);
    end

    always_comb begin
        e2       = {err_q, 1'b0};
        dx_wide  = dx_q;
        dy_wide  = dy_q;
        step_x   = e2 >= dy_wide;
        step_y   = e2 <= dx_wide;
        err_step = err_q
                 + (step_x ? dy_q : '0)
                 + (step_y ? dx_q : '0);
        addr_dx  = '0;
        addr_dy  = '0;
        if (step_x)
            addr_dx = sx_neg_q ? '1 : pixel_address_t'(1);
        if (step_y)
            addr_dy = sy_neg_q ? ('0 - ROW_STRIDE) : ROW_STRIDE;
        at_end   = (x_q == x1_q) && (y_q == y1_q);
        advance  = (state_q == DRAW) && pixel_write_grant_in && !at_end;
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (draw_start_in) state_d = SETUP;
            SETUP: state_d = DRAW;
            DRAW:  if (pixel_write_grant_in && at_end) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they come straight off flops.
    always_comb begin
        busy_d   = state_d != IDLE;
        enable_d = state_d == DRAW;
        done_d   = state_d == DONE;
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            x_q      <= '0;
            y_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (draw_start_in) begin
                        x_q     <= clamp_coord(cursor_start_x_position_in, MAX_X);
                        y_q     <= clamp_coord(cursor_start_y_position_in, MAX_Y);
                        x1_q    <= clamp_coord(line_end_x_in, MAX_X);
                        y1_q    <= clamp_coord(line_end_y_in, MAX_Y);
                        color_q <= color_index_in;
                    end
                end
                SETUP: begin
                    dx_q     <= dx_init;
                    dy_q     <= dy_init;
                    err_q    <= dx_init + dy_init;
                    sx_neg_q <= x1_q < x_q;
                    sy_neg_q <= y1_q < y_q;
                    addr_q   <= row_base;
                end
                DRAW: begin
                    if (advance) begin
                        err_q  <= err_step;
                        addr_q <= addr_q + addr_dx + addr_dy;
                        if (step_x)
                            x_q <= x_q + (sx_neg_q ? '1 : coord_t'(1));
                        if (step_y)
                            y_q <= y_q + (sy_neg_q ? '1 : coord_t'(1));
                    end
                end
                DONE: ;
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            busy_q   <= 1'b0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            end_x_q  <= '0;
            end_y_q  <= '0;
        end else begin
            busy_q   <= busy_d;
            enable_q <= enable_d;
            done_q   <= done_d;
            if (state_q == SETUP)
                data_q <= color_q;
            if (done_d && !done_q) begin
                end_x_q <= x1_q;
                end_y_q <= y1_q;
            end
        end
    end

    assign busy_out                      = busy_q;
    assign pixel_write_enable_out        = enable_q;
    assign pixel_write_address_out       = addr_q;
    assign pixel_write_data_out          = data_q;
    assign cursor_end_position_valid_out = done_q;
    assign cursor_end_x_position_out     = end_x_q;
    assign cursor_end_y_position_out     = end_y_q;

endmodule

// File: tb/tb_vector_engine.sv
// Scoreboard bench for vector_engine: directed lines, stall, clamp,
// mid-line reset and start-while-busy.
module tb_vector_engine;

    logic        clock_in = 1'b0;
    logic        reset_n_in;
    logic [9:0]  cursor_start_x_position_in;
    logic [9:0]  cursor_start_y_position_in;
    logic [9:0]  line_end_x_in;
    logic [9:0]  line_end_y_in;
    logic [3:0]  color_index_in;
    logic        draw_start_in;
    logic        pixel_write_grant_in;
    logic        busy_out;
    logic        pixel_write_enable_out;
    logic [17:0] pixel_write_address_out;
    logic [3:0]  pixel_write_data_out;
    logic        cursor_end_position_valid_out;
    logic [9:0]  cursor_end_x_position_out;
    logic [9:0]  cursor_end_y_position_out;

    vector_engine dut (
        .clock_in                      (clock_in),
        .reset_n_in                    (reset_n_in),
        .cursor_start_x_position_in    (cursor_start_x_position_in),
        .cursor_start_y_position_in    (cursor_start_y_position_in),
        .line_end_x_in                 (line_end_x_in),
        .line_end_y_in                 (line_end_y_in),
        .color_index_in                (color_index_in),
        .draw_start_in                 (draw_start_in),
        .pixel_write_grant_in          (pixel_write_grant_in),
        .busy_out                      (busy_out),
        .pixel_write_enable_out        (pixel_write_enable_out),
        .pixel_write_address_out       (pixel_write_address_out),
        .pixel_write_data_out          (pixel_write_data_out),
        .cursor_end_position_valid_out (cursor_end_position_valid_out),
        .cursor_end_x_position_out     (cursor_end_x_position_out),
        .cursor_end_y_position_out     (cursor_end_y_position_out)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int x;
        int y;
    } cur_t;

    wr_t  exp_w[$];
    cur_t exp_c[$];
    wr_t  mon_w;
    cur_t mon_c;
    int   checks   = 0;
    int   passes   = 0;
    int   accepted = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req)
            passes++;
        else
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    // Monitor: pops the scoreboard on every accepted write and cursor pulse.
    always @(negedge clock_in) begin
        if (pixel_write_enable_out && pixel_write_grant_in) begin
            accepted++;
            if (exp_w.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write actual=%0d required=none",
                         pixel_write_address_out);
            end else begin
                mon_w = exp_w.pop_front();
                check("wr_addr", int'(pixel_write_address_out), mon_w.addr);
                check("wr_data", int'(pixel_write_data_out), mon_w.data);
            end
        end
        if (cursor_end_position_valid_out) begin
            if (exp_c.size() == 0) begin
                checks++;
                $display("FAIL unexpected_cursor actual=%0d,%0d required=none",
                         cursor_end_x_position_out, cursor_end_y_position_out);
            end else begin
                mon_c = exp_c.pop_front();
                check("cursor_x", int'(cursor_end_x_position_out), mon_c.x);
                check("cursor_y", int'(cursor_end_y_position_out), mon_c.y);
            end
        end
    end

    task automatic expect_line(input int addrs[$], input int col,
                               input int cx, input int cy);
        foreach (addrs[i]) exp_w.push_back('{addrs[i], col});
        exp_c.push_back('{cx, cy});
    endtask

    task automatic drive(input int x0, input int y0, input int x1,
                         input int y1, input int col);
        cursor_start_x_position_in = 10'(x0);
        cursor_start_y_position_in = 10'(y0);
        line_end_x_in              = 10'(x1);
        line_end_y_in              = 10'(y1);
        color_index_in             = 4'(col);
    endtask

    task automatic pulse_start();
        draw_start_in = 1'b1;
        @(posedge clock_in); #1;
        draw_start_in = 1'b0;
    endtask

    task automatic finish_line(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cursor_end_position_valid_out) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock_in); #1;
        end
        check({name, "_cursor_seen"}, int'(seen), 1);
        @(posedge clock_in); #1;
        check({name, "_busy_low"}, int'(busy_out), 0);
        check({name, "_pulse_width"}, int'(cursor_end_position_valid_out), 0);
        check({name, "_writes_left"}, exp_w.size(), 0);
        check({name, "_cursor_left"}, exp_c.size(), 0);
    endtask

    task automatic run_line(input string name, input int x0, input int y0,
                            input int x1, input int y1, input int col,
                            input bit interfere);
        drive(x0, y0, x1, y1, col);
        pulse_start();
        check({name, "_busy_next"}, int'(busy_out), 1);
        check({name, "_en_cycle1"}, int'(pixel_write_enable_out), 0);
        @(posedge clock_in); #1;
        check({name, "_en_cycle2"}, int'(pixel_write_enable_out), 1);
        if (interfere) begin
            drive(100, 100, 200, 150, 9);
            pulse_start();
        end
        finish_line(name);
    endtask

    initial begin
        reset_n_in           = 1'b1;
        draw_start_in        = 1'b0;
        pixel_write_grant_in = 1'b1;
        drive(0, 0, 0, 0, 0);
        #2 reset_n_in = 1'b0;
        #1;
        check("rst_busy", int'(busy_out), 0);
        check("rst_en", int'(pixel_write_enable_out), 0);
        check("rst_addr", int'(pixel_write_address_out), 0);
        check("rst_cursor", int'(cursor_end_position_valid_out), 0);
        repeat (2) @(posedge clock_in);
        #1 reset_n_in = 1'b1;
        @(posedge clock_in); #1;

        expect_line('{0, 1, 2, 3}, 5, 3, 0);
        run_line("horiz", 0, 0, 3, 0, 5, 1'b0);

        expect_line('{0, 641, 642, 1283, 1284}, 1, 4, 2);
        run_line("shallow", 0, 0, 4, 2, 1, 1'b0);

        expect_line('{3205, 2564, 1923, 1282}, 2, 2, 2);
        run_line("rdiag", 5, 5, 2, 2, 2, 1'b0);

        expect_line('{1290, 1930, 2570}, 15, 10, 4);
        run_line("vert", 10, 2, 10, 4, 15, 1'b0);

        expect_line('{255999}, 9, 639, 399);
        run_line("clamp", 639, 399, 700, 450, 9, 1'b0);

        expect_line('{0, 1, 2, 3}, 6, 3, 0);
        run_line("busy_start", 0, 0, 3, 0, 6, 1'b1);

        // Stall while the second pixel of a reversed diagonal is presented.
        expect_line('{3205, 2564, 1923, 1282}, 7, 2, 2);
        drive(5, 5, 2, 2, 7);
        pulse_start();
        @(posedge clock_in); #1;
        check("stall_first", int'(pixel_write_address_out), 3205);
        @(posedge clock_in); #1;
        pixel_write_grant_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock_in); #1;
            check("stall_en", int'(pixel_write_enable_out), 1);
            check("stall_addr", int'(pixel_write_address_out), 2564);
            check("stall_data", int'(pixel_write_data_out), 7);
        end
        pixel_write_grant_in = 1'b1;
        finish_line("stall");

        // Reset after the third accepted write of a long horizontal line.
        exp_w.push_back('{0, 3});
        exp_w.push_back('{1, 3});
        exp_w.push_back('{2, 3});
        accepted = 0;
        drive(0, 0, 9, 0, 3);
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            if (accepted >= 3) break;
            @(posedge clock_in); #1;
        end
        check("rstmid_reached", accepted, 3);
        reset_n_in = 1'b0;
        #1;
        check("rstmid_busy", int'(busy_out), 0);
        check("rstmid_en", int'(pixel_write_enable_out), 0);
        check("rstmid_addr", int'(pixel_write_address_out), 0);
        check("rstmid_data", int'(pixel_write_data_out), 0);
        check("rstmid_cursor", int'(cursor_end_position_valid_out), 0);
        check("rstmid_end_x", int'(cursor_end_x_position_out), 0);
        repeat (2) @(posedge clock_in);
        #1 reset_n_in = 1'b1;
        repeat (20) @(posedge clock_in);
        #1;
        check("rstmid_no_more", accepted, 3);
        check("rstmid_busy_after", int'(busy_out), 0);
        check("rstmid_writes_left", exp_w.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vector_engine.md
Name: vector_engine

Overview:
Line-drawing engine that fills the vector slot of the graphics pixel-write mux, alongside the sprite engine, and writes into display_buffers.
- On a start pulse it rasterises one straight line from the current cursor to a supplied end point using integer Bresenham.
- It emits one palette-indexed pixel write per accepted cycle.
- When finished it reports the end point so the cursor register can be updated.

Parameters:
DISPLAY_WIDTH, 640, pixels per row; row stride of the linear buffer address
DISPLAY_HEIGHT, 400, rows
COORD_WIDTH, 10, coordinate bit width
ADDRESS_WIDTH, 18, pixel buffer address width (640*400 = 256000 < 2^18)
ERROR_WIDTH, 12, signed Bresenham error/delta width

Ports:
clock_in  input  1  system clock
reset_n_in  input  1  reset; asynchronous, active-low
cursor_start_x_position_in  input  10  line start x, sampled on draw_start_in
cursor_start_y_position_in  input  10  line start y, sampled on draw_start_in
line_end_x_in  input  10  line end x, sampled on draw_start_in
line_end_y_in  input  10  line end y, sampled on draw_start_in
color_index_in  input  4  palette index, sampled on draw_start_in
draw_start_in  input  1  one-cycle start pulse
pixel_write_grant_in  input  1  mux accepted the presented pixel this cycle
busy_out  output  1  line in progress
pixel_write_enable_out  output  1  pixel write request
pixel_write_address_out  output  18  y*640+x
pixel_write_data_out  output  4  palette index
cursor_end_position_valid_out  output  1  one-cycle pulse, line complete
cursor_end_x_position_out  output  10  final x
cursor_end_y_position_out  output  10  final y

Behaviour:
- Reset (asynchronous, active-low; legal at any time, including mid-line):
  - state goes to IDLE; all outputs 0.
  - a partially drawn line is abandoned; no cursor pulse is produced.
- All outputs are registered.
- States: IDLE -> SETUP -> DRAW -> DONE -> IDLE.
- IDLE:
  - draw_start_in=1 captures the inputs; go to SETUP; busy_out=1 from the next cycle.
  - coordinates are clamped on capture: x>639 becomes 639, y>399 becomes 399.
- SETUP (1 cycle):
  - dx=|x1-x0|, dy=-|y1-y0|, sx=+/-1, sy=+/-1, err=dx+dy.
  - start address = (y0<<9)+(y0<<7)+x0, computed with shift-add and no multiplier.
  - go to DRAW with the first pixel presented.
  - latency: first pixel_write_enable_out=1 appears 2 cycles after the start pulse.
- DRAW:
  - pixel_write_enable_out=1; address and data are held stable until a cycle with pixel_write_grant_in=1.
  - on grant, if (x,y)==(x1,y1): go to DONE.
  - otherwise advance using e2=2*err:
    - if e2>=dy: err+=dy, x+=sx, address+=sx.
    - if e2<=dx: err+=dx, y+=sy, address+=sy*640.
    - both steps may occur in the same cycle; the error update uses the pre-step err.
  - the next pixel is presented in the following cycle, giving 1 pixel/cycle under continuous grant.
- Pixel count = max(dx,|dy|)+1.
- The pixel sequence runs from start to end inclusive, with no duplicate pixels.
- DONE (1 cycle):
  - pixel_write_enable_out=0; cursor_end_position_valid_out=1; end x,y = clamped (x1,y1).
  - busy_out=0 from the next cycle (IDLE).
- draw_start_in while busy_out=1 is ignored.
- pixel_write_grant_in while pixel_write_enable_out=0 is ignored.
- A zero-length line (start==end) writes exactly one pixel, then DONE.
- Address arithmetic is done in ADDRESS_WIDTH bits. After clamping it never leaves 0..255999, so there is no wrap.

Decomposition:
- graphics_pkg holds:
  - DISPLAY_WIDTH, DISPLAY_HEIGHT, COORD_WIDTH, ADDRESS_WIDTH as localparams;
  - typedef vector_state_t {IDLE, SETUP, DRAW, DONE};
  - typedef pixel_address_t (logic [17:0]).
- Single module. No sub-module: the stepper and address tracker are one datapath sharing the grant enable.

Test Plan:
- Horizontal line, cursor (0,0), end (3,0), color 5, grant=1 -> writes at addresses 0,1,2,3 with data 5 on consecutive cycles, the first 2 cycles after start; then a cursor pulse with (3,0); busy_out low the next cycle.
- Shallow line, (0,0)->(4,2) -> addresses 0,641,642,1283,1284.
- Reversed diagonal, (5,5)->(2,2) -> addresses 3205,2564,1923,1282.
- Vertical line, (10,2)->(10,4) -> addresses 1290,1930,2570.
- Stall on a reversed diagonal, (5,5)->(2,2): grant=0 for 3 cycles while the 2nd pixel (2564) is presented -> enable, address 2564 and data held all 3 cycles; the sequence resumes unchanged; exactly 4 writes.
- Single point with clamping, (639,399)->(700,450) -> end clamped to (639,399); exactly one write at 255999; cursor pulse (639,399).
- Reset mid-line: on (0,0)->(9,0), assert reset_n_in after the 3rd accepted write -> all outputs 0 immediately, no cursor pulse, and no further writes after release.
- Start while busy: pulse draw_start_in during a line -> ignored; the original line completes unchanged.
